nibble_serial_add_ctrl: RTL and testbench

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nibble_serial_add_ctrl_if.sv | 28 ++
 rtl/nibble_serial_add_ctrl.sv | 87 ++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: request/result handshake and external 4-bit adder bus
interface nibble_serial_add_ctrl_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         sub;
  logic [3:0]   cla_a;
  logic [3:0]   cla_b;
  logic         cla_cin;
  logic [3:0]   cla_sum;
  logic         cla_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  modport slave (
    input  in_valid, a, b, carry_in, sub, cla_sum, cla_cout, out_ready,
    output in_ready, cla_a, cla_b, cla_cin, out_valid, sum, carry_out, overflow
  );
  modport master (
    output in_valid, a, b, carry_in, sub, cla_sum, cla_cout, out_ready,
    input  in_ready, cla_a, cla_b, cla_cin, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: sequences a W-bit add/sub one nibble per cycle through an external 4-bit adder
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic                   clk,
  input logic                   rst,
  nibble_serial_add_ctrl_if.slave io
);
  localparam int CW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NIBBLES-1:0][3:0]  a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic                     cin_q, cin_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic                     run, last;
  assign run  = state_q == RUN;
  assign last = cnt_q == CW'(NIBBLES - 1);
  assign io.in_ready  = state_q == IDLE && !rst;
  assign io.out_valid = state_q == DONE;
  assign io.sum       = sum_q;
  assign io.carry_out = cout_q;
  assign io.overflow  = ovf_q;
  assign io.cla_a     = run ? a_q[cnt_q] : 4'h0;
  assign io.cla_b     = run ? b_q[cnt_q] : 4'h0;
  assign io.cla_cin   = run && (cnt_q == '0 ? cin_q : carry_q);
  // Next-state: capture operands on accept, collect one nibble per RUN cycle, publish on the last one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (io.in_valid) begin
        a_d     = io.a;
        b_d     = io.sub ? ~io.b : io.b;
        cin_d   = io.sub | io.carry_in;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d[cnt_q] = io.cla_sum;
        carry_d      = io.cla_cout;
        cnt_d        = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          sum_d   = acc_d;
          cout_d  = io.cla_cout;
          ovf_d   = (a_q[NIBBLES-1][3] ^ io.cla_sum[3]) & (b_q[NIBBLES-1][3] ^ io.cla_sum[3]);
          state_d = DONE;
        end
      end
      DONE: if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State register; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: randomized and directed checks against an arithmetic reference model
module tb_nibble_serial_add_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc[$];
  always #5 clk = ~clk;
  nibble_serial_add_ctrl_if #(.NIBBLES(N)) bus();
  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .io(bus));
  assign {bus.cla_cout, bus.cla_sum} = {1'b0, bus.cla_a} + {1'b0, bus.cla_b} + {4'b0, bus.cla_cin};
  always @(posedge clk) begin
    cyc++;
    if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
  end
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    longint sa, sb, ss;
    logic [W:0] r;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r[W-1:0] = a - b;
      r[W] = a >= b;
      ss = sa - sb;
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      ss = sa + sb + longint'(cin);
    end
    ovf = ss > (64'sd1 <<< (W - 1)) - 1 || ss < -(64'sd1 <<< (W - 1));
    return {ovf, r};
  endfunction
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub,
                       output logic [W+1:0] got, output int lat, output logic moved);
    logic [W-1:0] prev;
    int wait_n;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.carry_in = cin;
    bus.sub = sub;
    bus.in_valid = 1'b1;
    wait_n = 0;
    while (!bus.in_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.sub = 1'($urandom);
    prev = bus.sum;
    moved = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid && bus.sum !== prev) moved = 1'b1;
    end
    got = {bus.overflow, bus.carry_out, bus.sum};
  endtask
  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if ({bus.overflow, bus.carry_out, bus.sum} !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {bus.overflow, bus.carry_out, bus.sum}); end
    total++; if ({bus.cla_a, bus.cla_b, bus.cla_cin} !== '0) begin bad++; $display("FAIL reset_cla got=%h exp=0", {bus.cla_a, bus.cla_b, bus.cla_cin}); end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid got=%b exp=0", bus.out_valid); end
  endtask
  task automatic test_directed();
    logic [W-1:0] va[5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [W-1:0] vb[5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic         vc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         vs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W+1:0] ve[5] = '{{2'b00, 16'h5555}, {2'b01, 16'h0000}, {2'b10, 16'h8000}, {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}};
    logic [W+1:0] got;
    int lat;
    logic moved;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vc[i], vs[i], got, lat, moved);
      total++; if (got !== ve[i]) begin bad++; $display("FAIL directed%0d_result got=%h exp=%h", i, got, ve[i]); end
      total++; if (got !== model(va[i], vb[i], vc[i], vs[i])) begin bad++; $display("FAIL directed%0d_model got=%h exp=%h", i, got, model(va[i], vb[i], vc[i], vs[i])); end
      total++; if (lat !== N) begin bad++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, N); end
      total++; if (moved !== 1'b0) begin bad++; $display("FAIL directed%0d_sum_early got=%b exp=0", i, moved); end
      release_out();
      total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin bad++; $display("FAIL directed%0d_release got=%b exp=01", i, {bus.out_valid, bus.in_ready}); end
    end
  endtask
  task automatic test_backpressure();
    logic [W+1:0] got, exp;
    int lat;
    logic moved;
    exp = model(16'hA5C3, 16'h3C5A, 1'b1, 1'b0);
    do_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b0, got, lat, moved);
    total++; if (got !== exp) begin bad++; $display("FAIL bp_result got=%h exp=%h", got, exp); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin bad++; $display("FAIL bp_hold%0d_flags got=%b exp=10", i, {bus.out_valid, bus.in_ready}); end
      total++; if ({bus.overflow, bus.carry_out, bus.sum} !== exp) begin bad++; $display("FAIL bp_hold%0d_data got=%h exp=%h", i, {bus.overflow, bus.carry_out, bus.sum}, exp); end
    end
    release_out();
    total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin bad++; $display("FAIL bp_release got=%b exp=01", {bus.out_valid, bus.in_ready}); end
  endtask
  task automatic test_reset_mid_run();
    logic [W+1:0] got, exp;
    int lat;
    logic moved;
    logic seen;
    @(negedge clk);
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.sub = 1'b0;
    bus.carry_in = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrun_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.sum !== '0) begin bad++; $display("FAIL midrun_sum got=%h exp=0", bus.sum); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL midrun_in_ready got=%b exp=0", bus.in_ready); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrun_no_pulse got=%b exp=0", seen); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrun_idle got=%b exp=1", bus.in_ready); end
    exp = model(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, got, lat, moved);
    total++; if (got !== exp) begin bad++; $display("FAIL midrun_next_result got=%h exp=%h", got, exp); end
    total++; if (lat !== N) begin bad++; $display("FAIL midrun_next_latency got=%0d exp=%0d", lat, N); end
    release_out();
  endtask
  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    logic [W+1:0] res[2];
    int n_res;
    a1 = W'($urandom);
    b1 = W'($urandom);
    a2 = W'($urandom);
    b2 = W'($urandom);
    n_res = 0;
    @(negedge clk);
    acc_cyc.delete();
    bus.out_ready = 1'b1;
    bus.a = a1;
    bus.b = b1;
    bus.sub = 1'b0;
    bus.carry_in = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (acc_cyc.size() == 1) begin
        bus.a = a2;
        bus.b = b2;
        bus.sub = 1'b1;
      end
      if (acc_cyc.size() >= 2) bus.in_valid = 1'b0;
      if (bus.in_ready || bus.out_valid) begin
        total++; if ({bus.cla_a, bus.cla_b, bus.cla_cin} !== '0) begin bad++; $display("FAIL b2b_cla_idle got=%h exp=0", {bus.cla_a, bus.cla_b, bus.cla_cin}); end
      end
      if (bus.out_valid) begin
        if (n_res < 2) res[n_res] = {bus.overflow, bus.carry_out, bus.sum};
        n_res++;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    total++; if (acc_cyc.size() !== 2) begin bad++; $display("FAIL b2b_accepts got=%0d exp=2", acc_cyc.size()); end
    if (acc_cyc.size() == 2) begin
      total++; if (acc_cyc[1] - acc_cyc[0] !== N + 2) begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", acc_cyc[1] - acc_cyc[0], N + 2); end
    end
    total++; if (n_res !== 2) begin bad++; $display("FAIL b2b_results got=%0d exp=2", n_res); end
    total++; if (res[0] !== model(a1, b1, 1'b0, 1'b0)) begin bad++; $display("FAIL b2b_first got=%h exp=%h", res[0], model(a1, b1, 1'b0, 1'b0)); end
    total++; if (res[1] !== model(a2, b2, 1'b0, 1'b1)) begin bad++; $display("FAIL b2b_second got=%h exp=%h", res[1], model(a2, b2, 1'b0, 1'b1)); end
  endtask
  task automatic test_random();
    logic [W-1:0] a, b;
    logic cin, sub;
    logic [W+1:0] got, exp;
    int lat;
    logic moved;
    for (int i = 0; i < 25; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      exp = model(a, b, cin, sub);
      do_op(a, b, cin, sub, got, lat, moved);
      total++; if (got !== exp) begin bad++; $display("FAIL rand%0d_result a=%h b=%h cin=%b sub=%b got=%h exp=%h", i, a, b, cin, sub, got, exp); end
      total++; if (lat !== N) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, N); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      total++; if ({bus.overflow, bus.carry_out, bus.sum} !== exp) begin bad++; $display("FAIL rand%0d_hold got=%h exp=%h", i, {bus.overflow, bus.carry_out, bus.sum}, exp); end
      release_out();
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.carry_in = 1'b0;
    bus.sub = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
